ctx_seq: RTL and testbench
==========================

Name: ctx_seq

Overview:
- Sequencer directly downstream of the instruction decoder.
- Registers the decoder's state_mode_next into state_mode and runs the sequence counter sc that the decoder consumes.
- During CALL, it spills the 16 general registers to a frame-organised context stack; during RET, it restores them.
- Holds fetch/PC (stall) while a sequence is in flight.

Parameters:
- FRAMES, 8, number of 16-word context frames in the stack memory (power of 2, ≥2)
- DW, 32, register/stack data width
- AW, $clog2(FRAMES)+4, stack memory word address width (derived, not overridable)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- state_mode_next  in  2  from decoder; 0=IMEM, 1=CALL, 2=RET, 3=reserved
- state_mode  out  2  registered current mode, fed back to decoder
- sc  out  8  sequence counter, fed back to decoder
- stall  out  1  high whenever state_mode != 0; freezes PC and fetch
- rf_raddr  out  4  register file read address (CALL spill)
- rf_rdata  in  DW  register file read data (combinational read)
- rf_waddr  out  4  register file write address (RET restore)
- rf_wdata  out  DW  register file write data
- rf_we  out  1  register file write strobe
- stk_addr  out  AW  stack memory word address
- stk_wdata  out  DW  stack memory write data
- stk_we  out  1  stack memory write strobe
- stk_rdata  in  DW  stack memory read data, 1-cycle synchronous read latency
- sp  out  $clog2(FRAMES)+1  frame stack pointer (occupied frames)
- err  out  1  sticky stack fault

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: state_mode=0, sc=0, sp=0, err=0. All strobes (stall, rf_we, stk_we) are 0.
- Reset mid-sequence aborts immediately. No partial sp update is made.
- IMEM (mode 0):
  - sc is held at 0.
  - state_mode_next is sampled every cycle. 1 → CALL, 2 → RET. 0 and 3 → stay in IMEM.
  - The request takes effect the next cycle, with sc=0.
- CALL/RET (modes 1/2):
  - state_mode_next is ignored.
  - sc increments by 1 each cycle from 0 to 16.
  - In the sc==16 cycle the next state is IMEM with sc=0, unconditionally.
  - Each sequence spends 17 cycles in-mode. The decoder sees sc==16 for exactly one cycle.
- CALL datapath:
  - For sc 0..15: rf_raddr=sc[3:0]; stk_we=1; stk_addr={sp[AW-5:0], sc[3:0]}; stk_wdata=rf_rdata.
  - At sc==16: no strobes; sp increments.
- RET datapath:
  - Frame index f = sp-1.
  - For sc 0..15: stk_addr={f, sc[3:0]} (read issue).
  - For sc 1..16: rf_we=1, rf_waddr=sc-1, rf_wdata=stk_rdata.
  - At sc==16: sp decrements.
- Strobe decoding: all strobes are decoded from the registered state_mode and sc, so they are glitch-free relative to flops.
- Mode 3 (reserved) is never entered.
- Ordering of updates: the sp update and the return to IMEM land on the same clock edge. A CALL/RET decoded in the first IMEM cycle afterwards sees the updated sp.

Optional Feature:
- Macro: CTX_SEQ_STACK_CHECK_EN.
- With the macro defined:
  - A CALL request with sp==FRAMES, or a RET request with sp==0, is refused. Mode stays 0, sp is unchanged, and no strobes fire.
  - err is set and stays set until reset.
- Without the macro:
  - err is tied 0.
  - sp wraps modulo 2*FRAMES. Stack addressing uses only the low $clog2(FRAMES) bits of sp, so overflow silently overwrites the oldest frame.

Decomposition:
- Shared package / opcodes.vh gets the mode encodings (MODE_IMEM=0, MODE_CALL=1, MODE_RET=2, MODE_RSVD=3) and SC_LAST=16, so the decoder and this block share one definition.
- One natural sub-module: ctx_stack_mem, a single-port synchronous-read RAM of FRAMES*16 x DW. It is instantiated at the top level next to ctx_seq, not inside it.

Test Plan:
- Reset, then drive state_mode_next=0 for 10 cycles → state_mode=0, sc=0, stall=0, sp=0, no strobes.
- Load r0..r15 with 0xA0+i, pulse state_mode_next=1 → 16 stk_we writes to addr 0..15 with data 0xA0..0xAF; sc reaches 16 once; sp=1 after; stall high for exactly 17 cycles.
- After that CALL, overwrite registers, pulse state_mode_next=2 → rf_we on sc 1..16, r0..r15 restored to 0xA0..0xAF; sp=0; mode 0 the following cycle.
- Nest 3 CALLs then 3 RETs with distinct register sets → frames 0, 1, 2 written at stk_addr bases 0x00/0x10/0x20; restores come back in LIFO order; sp sequence 1, 2, 3, 2, 1, 0.
- Drive state_mode_next toggling 0/3/1 mid-CALL → ignored; sequence completes at sc==16. state_mode_next=3 in IMEM → no mode change.
- Assert rst_n=0 at sc==7 of a CALL → next cycle state_mode=0, sc=0, sp unchanged (0).
- With CTX_SEQ_STACK_CHECK_EN and FRAMES=2:
  - RET at sp=0 → refused, err=1.
  - 3 CALLs → the third is refused, sp stays 2.

Source files
------------

// File: rtl/ctx_seq_pkg.sv
// Shared definitions for the context sequencer: mode encodings and sequence counter limits.
// Imported by the instruction decoder and ctx_seq so both agree on one encoding.
package ctx_seq_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_IMEM = 2'd0;
    localparam mode_t MODE_CALL = 2'd1;
    localparam mode_t MODE_RET  = 2'd2;
    localparam mode_t MODE_RSVD = 2'd3;

    // Last sequence count of a CALL/RET; the sequence occupies sc = 0..SC_LAST.
    localparam logic [7:0] SC_LAST = 8'd16;

    // Register-transfer part of a sequence (one register per count).
    function automatic logic sc_in_body(input logic [7:0] sc);
        return sc < SC_LAST;
    endfunction

    function automatic logic is_seq_mode(input mode_t mode);
        return (mode == MODE_CALL) || (mode == MODE_RET);
    endfunction

endpackage

// File: rtl/ctx_stack_mem.sv
// Context stack memory: single-port RAM of FRAMES*16 words, synchronous read with
// one cycle of latency, read-before-write on the shared port.
module ctx_stack_mem #(
    parameter int FRAMES = 8,
    parameter int DW     = 32,
    localparam int AW    = $clog2(FRAMES) + 4
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          we,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [FRAMES*16];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ctx_seq.sv
// Context sequencer: registers the decoder mode, runs sc, spills/restores r0..r15 on CALL/RET.
// Define CTX_SEQ_STACK_CHECK_EN to refuse stack overflow/underflow and raise a sticky err.
module ctx_seq
    import ctx_seq_pkg::*;
#(
    parameter int FRAMES = 8,
    parameter int DW     = 32,
    localparam int AW    = $clog2(FRAMES) + 4,
    localparam int SPW   = $clog2(FRAMES) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     state_mode_next,
    output logic [1:0]     state_mode,
    output logic [7:0]     sc,
    output logic           stall,
    output logic [3:0]     rf_raddr,
    input  logic [DW-1:0]  rf_rdata,
    output logic [3:0]     rf_waddr,
    output logic [DW-1:0]  rf_wdata,
    output logic           rf_we,
    output logic [AW-1:0]  stk_addr,
    output logic [DW-1:0]  stk_wdata,
    output logic           stk_we,
    input  logic [DW-1:0]  stk_rdata,
    output logic [SPW-1:0] sp,
    output logic           err
);

    localparam int FW = $clog2(FRAMES);

    mode_t          mode_q, mode_d;
    logic [7:0]     sc_q, sc_d;
    logic [SPW-1:0] sp_q, sp_d;

    logic req_call, req_ret;
    logic refuse_call, refuse_ret;

    assign req_call = (state_mode_next == MODE_CALL);
    assign req_ret  = (state_mode_next == MODE_RET);

`ifdef CTX_SEQ_STACK_CHECK_EN
    logic err_q;

    assign refuse_call = (sp_q == SPW'(FRAMES));
    assign refuse_ret  = (sp_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((mode_q == MODE_IMEM) &&
                     ((req_call && refuse_call) || (req_ret && refuse_ret))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign refuse_call = 1'b0;
    assign refuse_ret  = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        mode_d = mode_q;
        sc_d   = sc_q;
        sp_d   = sp_q;
        case (mode_q)
            MODE_IMEM: begin
                sc_d = 8'd0;
                if (req_call && !refuse_call) begin
                    mode_d = MODE_CALL;
                end else if (req_ret && !refuse_ret) begin
                    mode_d = MODE_RET;
                end
            end
            MODE_CALL, MODE_RET: begin
                if (sc_q == SC_LAST) begin
                    // sp moves on the same edge that returns to IMEM
                    mode_d = MODE_IMEM;
                    sc_d   = 8'd0;
                    sp_d   = (mode_q == MODE_CALL) ? sp_q + SPW'(1) : sp_q - SPW'(1);
                end else begin
                    sc_d = sc_q + 8'd1;
                end
            end
            default: begin
                mode_d = MODE_IMEM;
                sc_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_IMEM;
            sc_q   <= 8'd0;
            sp_q   <= '0;
        end else begin
            mode_q <= mode_d;
            sc_q   <= sc_d;
            sp_q   <= sp_d;
        end
    end

    logic [FW-1:0] frame_push, frame_pop;

    assign frame_push = sp_q[FW-1:0];
    assign frame_pop  = sp_q[FW-1:0] - FW'(1);

    // All strobes decode registered mode/sc only, so they never glitch on input changes.
    always_comb begin
        rf_raddr  = 4'd0;
        rf_waddr  = 4'd0;
        rf_wdata  = '0;
        rf_we     = 1'b0;
        stk_addr  = '0;
        stk_wdata = '0;
        stk_we    = 1'b0;
        if (mode_q == MODE_CALL && sc_in_body(sc_q)) begin
            rf_raddr  = sc_q[3:0];
            stk_addr  = {frame_push, sc_q[3:0]};
            stk_wdata = rf_rdata;
            stk_we    = 1'b1;
        end else if (mode_q == MODE_RET) begin
            if (sc_in_body(sc_q)) begin
                stk_addr = {frame_pop, sc_q[3:0]};
            end
            // Read data trails the address by one count, so writes cover sc 1..16.
            if (sc_q != 8'd0) begin
                rf_we    = 1'b1;
                rf_waddr = sc_q[3:0] - 4'd1;
                rf_wdata = stk_rdata;
            end
        end
    end

    assign state_mode = mode_q;
    assign sc         = sc_q;
    assign sp         = sp_q;
    assign stall      = is_seq_mode(mode_q);

endmodule

// File: tb/tb_ctx_seq.sv
// Scoreboard bench for ctx_seq with ctx_stack_mem and a behavioural register file.
// Builds with FRAMES=2 and overflow/underflow refusal when CTX_SEQ_STACK_CHECK_EN is defined.
module tb_ctx_seq;
    import ctx_seq_pkg::*;

`ifdef CTX_SEQ_STACK_CHECK_EN
    localparam int FRAMES = 2;
    localparam bit CHECK  = 1'b1;
`else
    localparam int FRAMES = 8;
    localparam bit CHECK  = 1'b0;
`endif
    localparam int DW  = 32;
    localparam int AW  = $clog2(FRAMES) + 4;
    localparam int SPW = $clog2(FRAMES) + 1;

    logic           clk;
    logic           rst_n;
    logic [1:0]     state_mode_next;
    logic [1:0]     state_mode;
    logic [7:0]     sc;
    logic           stall;
    logic [3:0]     rf_raddr;
    logic [DW-1:0]  rf_rdata;
    logic [3:0]     rf_waddr;
    logic [DW-1:0]  rf_wdata;
    logic           rf_we;
    logic [AW-1:0]  stk_addr;
    logic [DW-1:0]  stk_wdata;
    logic           stk_we;
    logic [DW-1:0]  stk_rdata;
    logic [SPW-1:0] sp;
    logic           err;

    ctx_seq #(.FRAMES(FRAMES), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .state_mode_next(state_mode_next),
        .state_mode(state_mode), .sc(sc), .stall(stall),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .rf_we(rf_we), .stk_addr(stk_addr),
        .stk_wdata(stk_wdata), .stk_we(stk_we), .stk_rdata(stk_rdata),
        .sp(sp), .err(err)
    );

    ctx_stack_mem #(.FRAMES(FRAMES), .DW(DW)) u_mem (
        .clk(clk), .addr(stk_addr), .wdata(stk_wdata), .we(stk_we), .rdata(stk_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational read, bench bulk-load port
    logic [DW-1:0] rf [16];
    logic [DW-1:0] tb_vals [16];
    logic          tb_load;

    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < 16; i++) rf[i] <= tb_vals[i];
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end
    assign rf_rdata = rf[rf_raddr];

    // Reference model: a LIFO of 16-word frames addressed modulo FRAMES
    logic [DW-1:0] m_stack [FRAMES][16];
    logic [DW-1:0] cur_regs [16];
    int            m_sp;
    bit            m_err;

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } stk_exp_t;
    typedef struct packed { logic [3:0] addr; logic [DW-1:0] data; } rf_exp_t;
    stk_exp_t q_stk[$];
    rf_exp_t  q_rf[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a write
    always @(negedge clk) begin
        stk_exp_t se;
        rf_exp_t  re;
        if (stk_we) begin
            if (q_stk.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stk_write_unexpected: got addr %0h data %0h, expected none",
                         stk_addr, stk_wdata);
            end else begin
                se = q_stk.pop_front();
                chk("stk_addr", 64'(stk_addr), 64'(se.addr));
                chk("stk_wdata", 64'(stk_wdata), 64'(se.data));
            end
        end
        if (rf_we) begin
            if (q_rf.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rf_write_unexpected: got addr %0h data %0h, expected none",
                         rf_waddr, rf_wdata);
            end else begin
                re = q_rf.pop_front();
                chk("rf_waddr", 64'(rf_waddr), 64'(re.addr));
                chk("rf_wdata", 64'(rf_wdata), 64'(re.data));
            end
        end
        if (state_mode == MODE_IMEM) chk("idle_strobes", {62'd0, stk_we, rf_we}, 64'd0);
    end

    function automatic bit accepts(input logic [1:0] m);
        if (!CHECK) return 1'b1;
        if (m == MODE_CALL) return m_sp < FRAMES;
        return m_sp > 0;
    endfunction

    task automatic load_regs(input bit pattern, input logic [DW-1:0] base);
        for (int i = 0; i < 16; i++) begin
            tb_vals[i]  = pattern ? base + DW'(i) : DW'($urandom);
            cur_regs[i] = tb_vals[i];
        end
        @(posedge clk); #1 tb_load = 1'b1;
        @(posedge clk); #1 tb_load = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] m);
        bit       acc;
        bit       done;
        int       f;
        int       stall_cnt;
        int       sc16;
        stk_exp_t se;
        rf_exp_t  re;
        acc = accepts(m);
        if (acc && m == MODE_CALL) begin
            f = m_sp % FRAMES;
            for (int i = 0; i < 16; i++) begin
                se.addr = AW'(f * 16 + i);
                se.data = cur_regs[i];
                q_stk.push_back(se);
                m_stack[f][i] = cur_regs[i];
            end
            m_sp = (m_sp + 1) % (2 * FRAMES);
        end else if (acc) begin
            f = (m_sp + 2 * FRAMES - 1) % FRAMES;
            for (int i = 0; i < 16; i++) begin
                re.addr = 4'(i);
                re.data = m_stack[f][i];
                q_rf.push_back(re);
                cur_regs[i] = m_stack[f][i];
            end
            m_sp = (m_sp + 2 * FRAMES - 1) % (2 * FRAMES);
        end else begin
            m_err = 1'b1;
        end

        @(posedge clk); #1 state_mode_next = m;
        @(posedge clk); #1 state_mode_next = acc ? 2'($urandom_range(0, 3)) : MODE_IMEM;
        stall_cnt = 0;
        sc16 = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall) begin
                chk("sc_seq", 64'(sc), 64'(stall_cnt));
                chk("mode_in_seq", 64'(state_mode), 64'(m));
                if (sc == 8'd16) sc16++;
                stall_cnt++;
                // Mid-sequence inputs are ignored; quiet the line before IMEM samples it again
                state_mode_next = (stall_cnt >= 16) ? MODE_IMEM : 2'($urandom_range(0, 3));
            end else if (stall_cnt > 0 || c >= 3) begin
                done = 1'b1;
            end
        end
        chk("stall_cycles", 64'(stall_cnt), acc ? 64'd17 : 64'd0);
        chk("sc16_once", 64'(sc16), acc ? 64'd1 : 64'd0);
        chk("mode_after", 64'(state_mode), 64'(MODE_IMEM));
        chk("sc_after", 64'(sc), 64'd0);
        chk("sp_after", 64'(sp), 64'(m_sp));
        chk("err_after", 64'(err), 64'(m_err));
        chk("scoreboard_drained", 64'(q_stk.size() + q_rf.size()), 64'd0);
    endtask

    task automatic idle_rsvd(input int n);
        @(posedge clk); #1 state_mode_next = MODE_RSVD;
        repeat (n) begin
            @(negedge clk);
            chk("rsvd_mode", 64'(state_mode), 64'(MODE_IMEM));
            chk("rsvd_stall", 64'(stall), 64'd0);
        end
        state_mode_next = MODE_IMEM;
    endtask

    task automatic reset_mid_call();
        stk_exp_t se;
        bit       hit;
        // Words 0..7 of frame 0 are written before the reset edge
        for (int i = 0; i < 8; i++) begin
            se.addr = AW'(i);
            se.data = cur_regs[i];
            q_stk.push_back(se);
            m_stack[0][i] = cur_regs[i];
        end
        @(posedge clk); #1 state_mode_next = MODE_CALL;
        @(posedge clk); #1 state_mode_next = MODE_IMEM;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (stall && sc == 8'd7) begin
                rst_n = 1'b0;
                hit = 1'b1;
            end
        end
        chk("reached_sc7", 64'(hit), 64'd1);
        @(negedge clk);
        m_sp = 0;
        m_err = 1'b0;
        chk("rst_mid_mode", 64'(state_mode), 64'(MODE_IMEM));
        chk("rst_mid_sc", 64'(sc), 64'd0);
        chk("rst_mid_sp", 64'(sp), 64'd0);
        chk("rst_mid_stall", 64'(stall), 64'd0);
        chk("rst_mid_drained", 64'(q_stk.size()), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] m;
        rst_n = 1'b0;
        state_mode_next = MODE_IMEM;
        tb_load = 1'b0;
        m_sp = 0;
        m_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mode", 64'(state_mode), 64'd0);
        chk("reset_sc", 64'(sc), 64'd0);
        chk("reset_sp", 64'(sp), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_strobes", {61'd0, stall, rf_we, stk_we}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_mode", 64'(state_mode), 64'd0);
            chk("idle_sc", 64'(sc), 64'd0);
            chk("idle_stall", 64'(stall), 64'd0);
            chk("idle_sp", 64'(sp), 64'd0);
        end
        idle_rsvd(5);

        if (CHECK) run_op(MODE_RET);

        load_regs(1'b1, 32'hA0);
        run_op(MODE_CALL);
        load_regs(1'b0, '0);
        run_op(MODE_RET);

        reset_mid_call();

        for (int k = 0; k < 3; k++) begin
            load_regs(1'b0, '0);
            run_op(MODE_CALL);
        end
        for (int k = 0; k < 3; k++) run_op(MODE_RET);

        // Without the check, 17 pushes wrap sp and overwrite the oldest frames
        if (!CHECK) begin
            for (int k = 0; k < 17; k++) begin
                load_regs(1'b0, '0);
                run_op(MODE_CALL);
            end
            for (int k = 0; k < 3; k++) run_op(MODE_RET);
        end

        for (int k = 0; k < 40; k++) begin
            if (CHECK) m = $urandom_range(0, 1) ? MODE_CALL : MODE_RET;
            else m = (m_sp == 0 || $urandom_range(0, 1) == 1) ? MODE_CALL : MODE_RET;
            if (m == MODE_CALL) load_regs(1'b0, '0);
            if ($urandom_range(0, 7) == 0) idle_rsvd(2);
            run_op(m);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
